// File: rtl/img2col_addr_gen.sv
`default_nettype none
`ifndef S2P_SIZE
`define S2P_SIZE 3
`endif
// +--------------------------------------------------------------------------+
// | Module   : img2col_addr_gen                                              |
// | Brief    : Walks every KxK window of a padded feature map, driving       |
// |            tensor/weight read addresses and padding controls per clk.    |
// |            IMG2COL_STRIDE_PORT_EN adds a runtime i_stride port.           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module img2col_addr_gen #(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int K        = `S2P_SIZE,
    parameter int STRIDE   = 1,
    parameter int PAD      = 1,
    parameter int T_ADDR_W = $clog2(IMG_W*IMG_H),
    parameter int W_ADDR_W = $clog2(K*K)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_go,
    input  logic                i_abort,
`ifdef IMG2COL_STRIDE_PORT_EN
    input  logic [1:0]          i_stride,
`endif
    output logic [T_ADDR_W-1:0] o_t_addr,
    output logic [W_ADDR_W-1:0] o_w_addr,
    output logic                o_start,
    output logic                o_t_padding_zero,
    output logic                o_w_padding_zero,
    output logic                o_busy,
    output logic                o_done
);
    localparam int CW     = T_ADDR_W + 2;
    localparam int SPAN_W = IMG_W + 2*PAD - K;
    localparam int SPAN_H = IMG_H + 2*PAD - K;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] c_one  = CW'(1);
    localparam logic [CW-1:0] c_kmax = CW'(K-1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_kx, r_ky, r_ox, r_oy, r_bx, r_by;
    logic [CW-1:0] w_kx, w_ky, w_ox, w_oy, w_bx, w_by;
    logic [CW-1:0] w_stride, w_out_w, w_out_h;
    logic [CW-1:0] w_ix, w_iy;
    logic          w_last, w_step, w_pad;

`ifdef IMG2COL_STRIDE_PORT_EN
    logic [CW-1:0] r_stride, r_out_w, r_out_h;
    logic [CW-1:0] w_go_stride, w_go_out_w, w_go_out_h;

    // Only strides 1..3 exist, so the output extents reduce to constant divisions.
    always_comb begin
        case (i_stride)
            2'd2: begin
                w_go_stride = CW'(2);
                w_go_out_w  = CW'(SPAN_W/2 + 1);
                w_go_out_h  = CW'(SPAN_H/2 + 1);
            end
            2'd3: begin
                w_go_stride = CW'(3);
                w_go_out_w  = CW'(SPAN_W/3 + 1);
                w_go_out_h  = CW'(SPAN_H/3 + 1);
            end
            default: begin
                w_go_stride = CW'(1);
                w_go_out_w  = CW'(SPAN_W + 1);
                w_go_out_h  = CW'(SPAN_H + 1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stride <= CW'(1);
            r_out_w  <= CW'(SPAN_W + 1);
            r_out_h  <= CW'(SPAN_H + 1);
        end else if (r_state == S_IDLE && i_go && !i_abort) begin
            r_stride <= w_go_stride;
            r_out_w  <= w_go_out_w;
            r_out_h  <= w_go_out_h;
        end
    end

    assign w_stride = r_stride;
    assign w_out_w  = r_out_w;
    assign w_out_h  = r_out_h;
`else
    assign w_stride = CW'(STRIDE);
    assign w_out_w  = CW'(SPAN_W/STRIDE + 1);
    assign w_out_h  = CW'(SPAN_H/STRIDE + 1);
`endif

    // Next element; r_bx/r_by accumulate ox*stride and oy*stride without a multiplier.
    always_comb begin
        w_kx = '0;
        w_ky = '0;
        w_ox = '0;
        w_oy = '0;
        w_bx = '0;
        w_by = '0;
        if (r_state == S_RUN) begin
            w_kx = r_kx + c_one;
            w_ky = r_ky;
            w_ox = r_ox;
            w_oy = r_oy;
            w_bx = r_bx;
            w_by = r_by;
            if (r_kx == c_kmax) begin
                w_kx = '0;
                w_ky = r_ky + c_one;
                if (r_ky == c_kmax) begin
                    w_ky = '0;
                    w_ox = r_ox + c_one;
                    w_bx = r_bx + w_stride;
                    if (r_ox == w_out_w - c_one) begin
                        w_ox = '0;
                        w_bx = '0;
                        w_oy = r_oy + c_one;
                        w_by = r_by + w_stride;
                        if (r_oy == w_out_h - c_one) begin
                            w_oy = '0;
                            w_by = '0;
                        end
                    end
                end
            end
        end
    end

    assign w_last = (r_kx == c_kmax) && (r_ky == c_kmax) &&
                    (r_ox == w_out_w - c_one) && (r_oy == w_out_h - c_one);
    assign w_step = ((r_state == S_IDLE) && i_go) || ((r_state == S_RUN) && !w_last);

    assign w_ix = w_bx + w_kx - CW'(PAD);
    assign w_iy = w_by + w_ky - CW'(PAD);
    // Negative coordinates wrap to large unsigned values, so one compare per axis covers both borders.
    assign w_pad = (w_ix >= CW'(IMG_W)) || (w_iy >= CW'(IMG_H));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state          <= S_IDLE;
            r_kx             <= '0;
            r_ky             <= '0;
            r_ox             <= '0;
            r_oy             <= '0;
            r_bx             <= '0;
            r_by             <= '0;
            o_t_addr         <= '0;
            o_w_addr         <= '0;
            o_start          <= 1'b0;
            o_t_padding_zero <= 1'b1;
            o_w_padding_zero <= 1'b1;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
        end else begin
            if (!i_abort && w_step) begin
                r_kx             <= w_kx;
                r_ky             <= w_ky;
                r_ox             <= w_ox;
                r_oy             <= w_oy;
                r_bx             <= w_bx;
                r_by             <= w_by;
                o_t_addr         <= w_pad ? '0 : T_ADDR_W'(w_iy * CW'(IMG_W) + w_ix);
                o_w_addr         <= W_ADDR_W'(w_ky * CW'(K) + w_kx);
                o_start          <= 1'b1;
                o_t_padding_zero <= w_pad;
                o_w_padding_zero <= 1'b0;
                o_busy           <= 1'b1;
            end else begin
                r_kx             <= '0;
                r_ky             <= '0;
                r_ox             <= '0;
                r_oy             <= '0;
                r_bx             <= '0;
                r_by             <= '0;
                o_t_addr         <= '0;
                o_w_addr         <= '0;
                o_start          <= 1'b0;
                o_t_padding_zero <= 1'b1;
                o_w_padding_zero <= 1'b1;
                o_busy           <= 1'b0;
            end
            o_done <= !i_abort && (r_state == S_RUN) && w_last;
            if (i_abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE:  if (i_go) r_state <= S_RUN;
                    S_RUN:   if (w_last) r_state <= S_DONE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_img2col_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_img2col_addr_gen                                           |
// | Brief    : Bench for img2col_addr_gen: default instance and a PAD=0,     |
// |            STRIDE=2 instance against an element-index reference model.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_img2col_addr_gen;
    logic       clk   = 1'b0;
    logic       rstn  = 1'b0;
    logic       go    = 1'b0;
    logic       abort = 1'b0;
    logic [5:0] t_addr0, t_addr1;
    logic [3:0] w_addr0, w_addr1;
    logic       start0, tpz0, wpz0, busy0, done0;
    logic       start1, tpz1, wpz1, busy1, done1;

    int n_pass   = 0;
    int n_checks = 0;
    int m_state [2];
    int m_idx   [2];
    int rec_ta  [2][576];
    int rec_tp  [2][576];

    always #5 clk = ~clk;

    img2col_addr_gen dut0 (
        .clk(clk), .rstn(rstn), .i_go(go), .i_abort(abort),
        .o_t_addr(t_addr0), .o_w_addr(w_addr0), .o_start(start0),
        .o_t_padding_zero(tpz0), .o_w_padding_zero(wpz0),
        .o_busy(busy0), .o_done(done0)
    );

    img2col_addr_gen #(.PAD(0), .STRIDE(2)) dut1 (
        .clk(clk), .rstn(rstn), .i_go(go), .i_abort(abort),
        .o_t_addr(t_addr1), .o_w_addr(w_addr1), .o_start(start1),
        .o_t_padding_zero(tpz1), .o_w_padding_zero(wpz1),
        .o_busy(busy1), .o_done(done1)
    );

    function automatic int cfg_pad(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic int cfg_str(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int out_dim(input int d);
        return (8 + 2*cfg_pad(d) - 3) / cfg_str(d) + 1;
    endfunction

    function automatic int frame_len(input int d);
        return out_dim(d) * out_dim(d) * 9;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Frame-level model: 0 idle, 1 showing element m_idx, 2 done pulse.
    always @(posedge clk or negedge rstn) begin
        for (int d = 0; d < 2; d++) begin
            if (!rstn) begin
                m_state[d] = 0;
                m_idx[d]   = 0;
            end else if (abort) begin
                m_state[d] = 0;
            end else if (m_state[d] == 0) begin
                if (go) begin
                    m_state[d] = 1;
                    m_idx[d]   = 0;
                end
            end else if (m_state[d] == 1) begin
                if (m_idx[d] == frame_len(d) - 1) m_state[d] = 2;
                else m_idx[d]++;
            end else begin
                m_state[d] = 0;
            end
        end
    end

    task automatic model_out(input int d, output int ta, output int wa, output int st,
                             output int tp, output int wp, output int bz, output int dn);
        int win, k, ox, oy, ix, iy, ow, p;
        ta = 0; wa = 0; st = 0; tp = 1; wp = 1; bz = 0;
        dn = (m_state[d] == 2) ? 1 : 0;
        if (m_state[d] == 1) begin
            ow  = out_dim(d);
            win = m_idx[d] / 9;
            k   = m_idx[d] % 9;
            ox  = win % ow;
            oy  = win / ow;
            ix  = ox*cfg_str(d) + k%3 - cfg_pad(d);
            iy  = oy*cfg_str(d) + k/3 - cfg_pad(d);
            p   = (ix < 0 || ix >= 8 || iy < 0 || iy >= 8) ? 1 : 0;
            ta  = p ? 0 : iy*8 + ix;
            wa  = k;
            st  = 1;
            tp  = p;
            wp  = 0;
            bz  = 1;
        end
    endtask

    task automatic check_dut(input int d, input int ta, input int wa, input int st,
                             input int tp, input int wp, input int bz, input int dn);
        int e_ta, e_wa, e_st, e_tp, e_wp, e_bz, e_dn;
        model_out(d, e_ta, e_wa, e_st, e_tp, e_wp, e_bz, e_dn);
        chk($sformatf("dut%0d.t_addr", d), ta, e_ta);
        chk($sformatf("dut%0d.w_addr", d), wa, e_wa);
        chk($sformatf("dut%0d.start", d), st, e_st);
        chk($sformatf("dut%0d.t_pad", d), tp, e_tp);
        chk($sformatf("dut%0d.w_pad", d), wp, e_wp);
        chk($sformatf("dut%0d.busy", d), bz, e_bz);
        chk($sformatf("dut%0d.done", d), dn, e_dn);
        if (m_state[d] == 1) begin
            rec_ta[d][m_idx[d]] = ta;
            rec_tp[d][m_idx[d]] = tp;
        end
    endtask

    always @(negedge clk) begin
        check_dut(0, int'(t_addr0), int'(w_addr0), int'(start0), int'(tpz0), int'(wpz0),
                  int'(busy0), int'(done0));
        check_dut(1, int'(t_addr1), int'(w_addr1), int'(start1), int'(tpz1), int'(wpz1),
                  int'(busy1), int'(done1));
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_t_addr0"}, int'(t_addr0), 0);
        chk({tag, "_w_addr0"}, int'(w_addr0), 0);
        chk({tag, "_start0"},  int'(start0),  0);
        chk({tag, "_tpz0"},    int'(tpz0),    1);
        chk({tag, "_wpz0"},    int'(wpz0),    1);
        chk({tag, "_busy0"},   int'(busy0),   0);
        chk({tag, "_done0"},   int'(done0),   0);
        chk({tag, "_start1"},  int'(start1),  0);
        chk({tag, "_busy1"},   int'(busy1),   0);
    endtask

    task automatic pulse_go();
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, cnt;
        int done_at [2];
        int starts  [2];
        int lit_ta  [9];
        int lit_tp  [9];

        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_values("idle");

        // Full frame on both instances, with a stray i_go mid-frame.
        pulse_go();
        n = 0;
        done_at = '{0, 0};
        starts  = '{0, 0};
        while (n < 2000 && (done_at[0] == 0 || done_at[1] == 0)) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("first_busy0", int'(busy0), 1);
                chk("first_start0", int'(start0), 1);
            end
            if (n == 50) go = 1'b1;
            if (n == 51) go = 1'b0;
            if (start0) starts[0]++;
            if (start1) starts[1]++;
            if (done0 && done_at[0] == 0) done_at[0] = n;
            if (done1 && done_at[1] == 0) done_at[1] = n;
        end
        chk("frame0_start_cycles", starts[0], 576);
        chk("frame0_done_cycle", done_at[0], 577);
        chk("frame1_start_cycles", starts[1], 81);
        chk("frame1_done_cycle", done_at[1], 82);

        lit_tp = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
        lit_ta = '{0, 0, 0, 0, 0, 1, 0, 8, 9};
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("win0_tpad[%0d]", i), rec_tp[0][i], lit_tp[i]);
            chk($sformatf("win0_taddr[%0d]", i), rec_ta[0][i], lit_ta[i]);
        end
        lit_tp = '{0, 0, 1, 0, 0, 1, 1, 1, 1};
        lit_ta = '{54, 55, 0, 62, 63, 0, 0, 0, 0};
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("winlast_tpad[%0d]", i), rec_tp[0][567+i], lit_tp[i]);
            chk($sformatf("winlast_taddr[%0d]", i), rec_ta[0][567+i], lit_ta[i]);
        end
        lit_ta = '{2, 3, 4, 10, 11, 12, 18, 19, 20};
        for (int i = 0; i < 9; i++)
            chk($sformatf("s2_win1_taddr[%0d]", i), rec_ta[1][9+i], lit_ta[i]);
        cnt = 0;
        for (int i = 0; i < 81; i++) cnt += rec_tp[1][i];
        chk("s2_padded_count", cnt, 0);

        // Abort while element 40 is on the outputs.
        repeat (5) @(posedge clk);
        pulse_go();
        repeat (39) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy0", int'(busy0), 0);
        chk("abort_start0", int'(start0), 0);
        chk("abort_busy1", int'(busy1), 0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            cnt += int'(done0) + int'(done1);
        end
        chk("abort_no_done", cnt, 0);
        pulse_go();
        @(negedge clk);
        chk("restart_w_addr0", int'(w_addr0), 0);
        chk("restart_tpz0", int'(tpz0), 1);
        chk("restart_busy0", int'(busy0), 1);
        repeat (600) @(negedge clk);

        // Asynchronous reset while element 100 is on the outputs.
        pulse_go();
        repeat (99) @(posedge clk);
        #2 rstn = 1'b0;
        #1 check_reset_values("midreset");
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_values("postreset");

        // Random go/abort traffic, including strobes during RUN and DONE.
        repeat (3000) begin
            @(negedge clk);
            go    = ($urandom_range(0, 24) == 0);
            abort = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        go    = 1'b0;
        abort = 1'b0;
        repeat (700) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
